// File: rtl/neighbor_builder.sv
// ---------------------------------------------------------------------------
// neighbor_builder
//
// Walks the triangle list held in object RAM and builds a per-vertex
// neighbour table in neighbour RAM for the downstream averaging stage.
// Entry for vertex v (0-based) starts at v*MAX_NEIGHBOR_COUNT: word 0 is the
// neighbour count, words 1..MAX_NEIGHBOR_COUNT-1 are 1-based neighbour
// indices in insertion order.
//
// Ports
//   clk, rst_n         clock (posedge) and asynchronous active-low reset
//   start              one-cycle pulse, begins a build when idle
//   vertex_count       number of vertices, sampled at start
//   face_count         number of triangles, sampled at start
//   RAM_OBJ_*          object RAM port (read only: WE/Di are tied to 0)
//   RAM_NBR_*          neighbour RAM port (read and full-word write)
//   busy               high from the cycle after start until done
//   done               one-cycle pulse when the table is complete
//   overflow           sticky: a neighbour was dropped, its list was full
//   idx_err            sticky: a face held an index 0 or >vertex_count
// ---------------------------------------------------------------------------
module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH         = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_OBJ_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [31:0]           RAM_OBJ_Di,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [3:0]            RAM_NBR_WE,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  idx_err
);

    localparam logic [31:0] MAX_W     = 32'(MAX_NEIGHBOR_COUNT);
    localparam logic [31:0] LAST_SLOT = MAX_W - 32'd1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_FACE_RD,
        S_EDGE,
        S_CNT_RD,
        S_SCAN,
        S_APPEND,
        S_CNT_WR,
        S_NEXT_FACE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [2:0]  pair_q, pair_d;
    logic [31:0] vc_q, vc_d;
    logic [31:0] fc_q, fc_d;
    logic [31:0] clr_idx_q, clr_idx_d;
    logic [31:0] face_idx_q, face_idx_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic [31:0] src_q, src_d;
    logic [31:0] nbr_q, nbr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] slot_q, slot_d;
    logic        overflow_q, overflow_d;
    logic        idx_err_q, idx_err_d;

    logic [ADDR_WIDTH-1:0] obj_a_c;
    logic [ADDR_WIDTH-1:0] nbr_a_c;
    logic [3:0]            nbr_we_c;
    logic [31:0]           nbr_di_c;
    logic                  busy_c;
    logic                  done_c;
    logic [31:0]           entry_base;
    logic [31:0]           clr_base;

    // A face index is usable only when it names an existing vertex (1-based).
    function automatic logic bad_idx(input logic [31:0] idx, input logic [31:0] vc);
        return (idx == 32'd0) || (idx > vc);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            pair_q     <= '0;
            vc_q       <= '0;
            fc_q       <= '0;
            clr_idx_q  <= '0;
            face_idx_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            src_q      <= '0;
            nbr_q      <= '0;
            cnt_q      <= '0;
            slot_q     <= '0;
            overflow_q <= 1'b0;
            idx_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            pair_q     <= pair_d;
            vc_q       <= vc_d;
            fc_q       <= fc_d;
            clr_idx_q  <= clr_idx_d;
            face_idx_q <= face_idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            src_q      <= src_d;
            nbr_q      <= nbr_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            overflow_q <= overflow_d;
            idx_err_q  <= idx_err_d;
        end
    end

    // Entry base addresses; wrap-around on the truncated address is accepted.
    always_comb begin
        entry_base = (src_q - 32'd1) * MAX_W;
        clr_base   = clr_idx_q * MAX_W;
    end

    // Next-state and output logic. Reads are split into an issue phase and a
    // capture phase (ph_q) to cover the one-cycle RAM read latency.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        pair_d     = pair_q;
        vc_d       = vc_q;
        fc_d       = fc_q;
        clr_idx_d  = clr_idx_q;
        face_idx_d = face_idx_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        src_d      = src_q;
        nbr_d      = nbr_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        overflow_d = overflow_q;
        idx_err_d  = idx_err_q;
        obj_a_c    = '0;
        nbr_a_c    = '0;
        nbr_we_c   = 4'b0000;
        nbr_di_c   = '0;
        busy_c     = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vc_d       = vertex_count;
                    fc_d       = face_count;
                    overflow_d = 1'b0;
                    idx_err_d  = 1'b0;
                    clr_idx_d  = '0;
                    face_idx_d = '0;
                    ph_d       = '0;
                    state_d    = S_CLEAR;
                end
            end

            S_CLEAR: begin
                busy_c  = 1'b1;
                nbr_a_c = ADDR_WIDTH'(clr_base);
                if (vc_q != 32'd0) begin
                    nbr_we_c = 4'b1111;
                end
                if ((vc_q == 32'd0) || (clr_idx_q == vc_q - 32'd1)) begin
                    ph_d    = '0;
                    state_d = (fc_q == 32'd0) ? S_DONE : S_FACE_RD;
                end else begin
                    clr_idx_d = clr_idx_q + 32'd1;
                end
            end

            // Phases 0..2 issue the three index reads; data trails by one phase.
            S_FACE_RD: begin
                busy_c  = 1'b1;
                obj_a_c = ADDR_WIDTH'(32'd3 * vc_q + 32'd3 * face_idx_q + {30'd0, ph_q});
                ph_d    = ph_q + 2'd1;
                case (ph_q)
                    2'd1:    a_d = RAM_OBJ_Do;
                    2'd2:    b_d = RAM_OBJ_Do;
                    2'd3: begin
                        c_d  = RAM_OBJ_Do;
                        ph_d = '0;
                        if (bad_idx(a_q, vc_q) || bad_idx(b_q, vc_q) ||
                            bad_idx(RAM_OBJ_Do, vc_q)) begin
                            idx_err_d = 1'b1;
                            state_d   = S_NEXT_FACE;
                        end else begin
                            pair_d  = '0;
                            state_d = S_EDGE;
                        end
                    end
                    default: ;
                endcase
            end

            S_EDGE: begin
                busy_c  = 1'b1;
                pair_d  = pair_q + 3'd1;
                ph_d    = '0;
                state_d = S_CNT_RD;
                case (pair_q)
                    3'd0:    begin src_d = a_q; nbr_d = b_q; end
                    3'd1:    begin src_d = a_q; nbr_d = c_q; end
                    3'd2:    begin src_d = b_q; nbr_d = a_q; end
                    3'd3:    begin src_d = b_q; nbr_d = c_q; end
                    3'd4:    begin src_d = c_q; nbr_d = a_q; end
                    3'd5:    begin src_d = c_q; nbr_d = b_q; end
                    default: begin
                        pair_d  = pair_q;
                        state_d = S_NEXT_FACE;
                    end
                endcase
            end

            S_CNT_RD: begin
                busy_c  = 1'b1;
                nbr_a_c = ADDR_WIDTH'(entry_base);
                if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else begin
                    cnt_d   = RAM_NBR_Do;
                    slot_d  = 32'd1;
                    ph_d    = '0;
                    state_d = S_SCAN;
                end
            end

            // slot_q > cnt_q also covers an empty list (slot starts at 1).
            S_SCAN: begin
                busy_c  = 1'b1;
                nbr_a_c = ADDR_WIDTH'(entry_base + slot_q);
                if (slot_q > cnt_q) begin
                    state_d = S_APPEND;
                end else if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else if (RAM_NBR_Do == nbr_q) begin
                    ph_d    = '0;
                    state_d = S_EDGE;
                end else begin
                    slot_d = slot_q + 32'd1;
                    ph_d   = '0;
                end
            end

            S_APPEND: begin
                busy_c = 1'b1;
                if (cnt_q >= LAST_SLOT) begin
                    overflow_d = 1'b1;
                    state_d    = S_EDGE;
                end else begin
                    nbr_a_c  = ADDR_WIDTH'(entry_base + cnt_q + 32'd1);
                    nbr_we_c = 4'b1111;
                    nbr_di_c = nbr_q;
                    state_d  = S_CNT_WR;
                end
            end

            S_CNT_WR: begin
                busy_c   = 1'b1;
                nbr_a_c  = ADDR_WIDTH'(entry_base);
                nbr_we_c = 4'b1111;
                nbr_di_c = cnt_q + 32'd1;
                state_d  = S_EDGE;
            end

            S_NEXT_FACE: begin
                busy_c     = 1'b1;
                face_idx_d = face_idx_q + 32'd1;
                ph_d       = '0;
                state_d    = (face_idx_q + 32'd1 == fc_q) ? S_DONE : S_FACE_RD;
            end

            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign RAM_OBJ_EN = busy_c;
    assign RAM_OBJ_A  = obj_a_c;
    assign RAM_OBJ_WE = 4'b0000;
    assign RAM_OBJ_Di = 32'd0;
    assign RAM_NBR_EN = busy_c;
    assign RAM_NBR_A  = nbr_a_c;
    assign RAM_NBR_WE = nbr_we_c;
    assign RAM_NBR_Di = nbr_di_c;
    assign busy       = busy_c;
    assign done       = done_c;
    assign overflow   = overflow_q;
    assign idx_err    = idx_err_q;

endmodule

// File: tb/tb_neighbor_builder.sv
// Bench for neighbor_builder: directed vector table, multi-cycle corner
// sequences (clear-only build, start while busy, reset mid-build) and
// randomized face lists checked against a list-based reference model.
module tb_neighbor_builder;

   localparam int MAXN = 10;
   localparam int AW   = 9;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] vertex_count = '0;
   logic [31:0] face_count = '0;
   logic [31:0] obj_do = '0;
   logic [31:0] nbr_do = '0;
   logic          RAM_OBJ_EN, RAM_NBR_EN, busy, done, overflow, idx_err;
   logic [AW-1:0] RAM_OBJ_A, RAM_NBR_A;
   logic [3:0]    RAM_OBJ_WE, RAM_NBR_WE;
   logic [31:0]   RAM_OBJ_Di, RAM_NBR_Di;

   neighbor_builder #(.MAX_NEIGHBOR_COUNT(MAXN), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .vertex_count(vertex_count), .face_count(face_count),
      .RAM_OBJ_Do(obj_do), .RAM_NBR_Do(nbr_do),
      .RAM_OBJ_EN(RAM_OBJ_EN), .RAM_OBJ_A(RAM_OBJ_A), .RAM_OBJ_WE(RAM_OBJ_WE),
      .RAM_OBJ_Di(RAM_OBJ_Di), .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_A(RAM_NBR_A),
      .RAM_NBR_WE(RAM_NBR_WE), .RAM_NBR_Di(RAM_NBR_Di),
      .busy(busy), .done(done), .overflow(overflow), .idx_err(idx_err)
   );

   always #5 clk = ~clk;

   // Synchronous RAM models with one-cycle read latency; the bench has its
   // own write port into neighbour RAM for preloading garbage.
   logic [31:0] obj_mem [0:511];
   logic [31:0] nbr_mem [0:511];
   logic        tb_wr = 1'b0;
   logic [8:0]  tb_wa = '0;
   logic [31:0] tb_wd = '0;

   always @(posedge clk) begin
      if (tb_wr) nbr_mem[tb_wa] <= tb_wd;
      else if (RAM_NBR_EN && RAM_NBR_WE == 4'hF) nbr_mem[RAM_NBR_A] <= RAM_NBR_Di;
      if (RAM_NBR_EN) nbr_do <= nbr_mem[RAM_NBR_A];
      if (RAM_OBJ_EN) obj_do <= obj_mem[RAM_OBJ_A];
   end

   // Event counters sampled mid-cycle.
   int done_cnt = 0;
   int we_cnt = 0;
   int obj_viol = 0;
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (RAM_NBR_EN && RAM_NBR_WE == 4'hF) we_cnt <= we_cnt + 1;
      if (RAM_OBJ_WE != 4'h0 || RAM_OBJ_Di != 32'd0) obj_viol <= obj_viol + 1;
   end

   typedef struct packed {
      logic [7:0]                vc;
      logic [7:0]                fc;
      logic [0:11][0:2][7:0]     faces;
      logic [0:11][0:9][7:0]     exp_tab;
      logic                      exp_ovf;
      logic                      exp_ierr;
   } vec_t;

   vec_t vecs [0:3];

   int cur_face [0:15][0:2];
   int exp_cnt [0:15];
   int exp_nb [0:15][0:9];
   int exp_ovf, exp_ierr;
   int lists [16][$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: per-vertex lists built straight from the face rules.
   task automatic refModel(input int vc, input int fc);
      int vs[3];
      bit found;
      for (int v = 0; v < 16; v++) lists[v].delete();
      exp_ovf = 0;
      exp_ierr = 0;
      for (int f = 0; f < fc; f++) begin
         for (int k = 0; k < 3; k++) vs[k] = cur_face[f][k];
         if (vs[0] < 1 || vs[0] > vc || vs[1] < 1 || vs[1] > vc || vs[2] < 1 || vs[2] > vc) begin
            exp_ierr = 1;
            continue;
         end
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               if (i == j) continue;
               found = 0;
               foreach (lists[vs[i]-1][k]) if (lists[vs[i]-1][k] == vs[j]) found = 1;
               if (!found) begin
                  if (lists[vs[i]-1].size() == MAXN - 1) exp_ovf = 1;
                  else lists[vs[i]-1].push_back(vs[j]);
               end
            end
         end
      end
      for (int v = 0; v < 16; v++) begin
         exp_cnt[v] = lists[v].size();
         for (int s = 0; s < lists[v].size(); s++) exp_nb[v][s+1] = lists[v][s];
      end
   endtask

   task automatic loadObjects(input int vc, input int fc);
      for (int i = 0; i < 3 * vc; i++) obj_mem[i] = $urandom;
      for (int f = 0; f < fc; f++)
         for (int k = 0; k < 3; k++) obj_mem[3*vc + 3*f + k] = cur_face[f][k];
   endtask

   task automatic fillGarbage();
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         tb_wr = 1'b1;
         tb_wa = 9'(i);
         tb_wd = $urandom | 32'd1;
      end
      @(negedge clk);
      tb_wr = 1'b0;
   endtask

   task automatic startBuild(input int vc, input int fc);
      vertex_count = vc;
      face_count = fc;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
   endtask

   task automatic checkTable(input string tag, input int vc);
      for (int v = 0; v < vc; v++) begin
         checkOutput($sformatf("%s_cnt_v%0d", tag, v), nbr_mem[v*MAXN], 32'(exp_cnt[v]));
         for (int s = 1; s <= exp_cnt[v] && s < MAXN; s++)
            checkOutput($sformatf("%s_nb_v%0d_s%0d", tag, v, s), nbr_mem[v*MAXN + s], 32'(exp_nb[v][s]));
      end
      checkOutput({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
      checkOutput({tag, "_idx_err"}, 32'(idx_err), 32'(exp_ierr));
   endtask

   task automatic applyStimulus(input string tag, input int vc, input int fc);
      int d0;
      loadObjects(vc, fc);
      fillGarbage();
      d0 = done_cnt;
      startBuild(vc, fc);
      waitDone(tag);
      repeat (2) @(negedge clk);
      checkOutput({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      checkTable(tag, vc);
   endtask

   task automatic loadVector(input int i);
      for (int f = 0; f < 12; f++)
         for (int k = 0; k < 3; k++) cur_face[f][k] = int'(vecs[i].faces[f][k]);
      for (int v = 0; v < 12; v++)
         for (int s = 0; s < MAXN; s++) exp_nb[v][s] = int'(vecs[i].exp_tab[v][s]);
      for (int v = 0; v < 12; v++) exp_cnt[v] = exp_nb[v][0];
      exp_ovf = int'(vecs[i].exp_ovf);
      exp_ierr = int'(vecs[i].exp_ierr);
   endtask

   function automatic logic [31:0] outputsOr();
      return 32'(|{busy, done, overflow, idx_err, RAM_OBJ_EN, RAM_NBR_EN, RAM_NBR_WE,
                   RAM_OBJ_WE, RAM_OBJ_A, RAM_NBR_A, RAM_OBJ_Di, RAM_NBR_Di});
   endfunction

   initial begin
      int busy_cycles, w0, gv, n, vc, fc;

      // Directed vector table.
      for (int i = 0; i < 4; i++) vecs[i] = '0;
      vecs[0].vc = 8'd3; vecs[0].fc = 8'd1;
      vecs[0].faces[0] = {8'd1, 8'd2, 8'd3};
      vecs[0].exp_tab[0] = {8'd2, 8'd2, 8'd3, 56'd0};
      vecs[0].exp_tab[1] = {8'd2, 8'd1, 8'd3, 56'd0};
      vecs[0].exp_tab[2] = {8'd2, 8'd1, 8'd2, 56'd0};

      vecs[1].vc = 8'd4; vecs[1].fc = 8'd2;
      vecs[1].faces[0] = {8'd1, 8'd2, 8'd3};
      vecs[1].faces[1] = {8'd2, 8'd4, 8'd3};
      vecs[1].exp_tab[0] = {8'd2, 8'd2, 8'd3, 56'd0};
      vecs[1].exp_tab[1] = {8'd3, 8'd1, 8'd3, 8'd4, 48'd0};
      vecs[1].exp_tab[2] = {8'd3, 8'd1, 8'd2, 8'd4, 48'd0};
      vecs[1].exp_tab[3] = {8'd2, 8'd2, 8'd3, 56'd0};

      // Fan of ten faces around vertex 1: eleven distinct neighbours, nine fit.
      vecs[2].vc = 8'd12; vecs[2].fc = 8'd10; vecs[2].exp_ovf = 1'b1;
      for (int k = 2; k <= 11; k++) vecs[2].faces[k-2] = {8'd1, 8'(k), 8'(k+1)};
      vecs[2].exp_tab[0][0] = 8'd9;
      for (int s = 1; s <= 9; s++) vecs[2].exp_tab[0][s] = 8'(s + 1);
      vecs[2].exp_tab[1] = {8'd2, 8'd1, 8'd3, 56'd0};
      for (int k = 3; k <= 11; k++) vecs[2].exp_tab[k-1] = {8'd3, 8'd1, 8'(k-1), 8'(k+1), 48'd0};
      vecs[2].exp_tab[11] = {8'd2, 8'd1, 8'd11, 56'd0};

      vecs[3].vc = 8'd3; vecs[3].fc = 8'd2; vecs[3].exp_ierr = 1'b1;
      vecs[3].faces[0] = {8'd1, 8'd0, 8'd2};
      vecs[3].faces[1] = {8'd1, 8'd2, 8'd3};
      vecs[3].exp_tab[0] = {8'd2, 8'd2, 8'd3, 56'd0};
      vecs[3].exp_tab[1] = {8'd2, 8'd1, 8'd3, 56'd0};
      vecs[3].exp_tab[2] = {8'd2, 8'd1, 8'd2, 56'd0};

      // Reset state.
      #2 rst_n = 1'b0;
      #1 checkOutput("reset_outputs", outputsOr(), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         loadVector(i);
         applyStimulus($sformatf("vec%0d", i), int'(vecs[i].vc), int'(vecs[i].fc));
      end

      // Clear-only build, with a start pulse injected while busy.
      loadObjects(5, 0);
      fillGarbage();
      gv = nbr_mem[50];
      w0 = we_cnt;
      n = done_cnt;
      startBuild(5, 0);
      busy_cycles = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         if (busy) busy_cycles++;
         start = (i == 2);
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("clr_busy_cycles", 32'(busy_cycles), 32'd5);
      checkOutput("clr_done", 32'(done), 32'd1);
      @(negedge clk);
      checkOutput("clr_idle_after", 32'({busy, done}), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("clr_done_pulses", 32'(done_cnt - n), 32'd1);
      checkOutput("clr_we_cycles", 32'(we_cnt - w0), 32'd5);
      checkOutput("clr_untouched_entry5", nbr_mem[50], gv);
      for (int v = 0; v < 5; v++) exp_cnt[v] = 0;
      exp_ovf = 0;
      exp_ierr = 0;
      checkTable("clr", 5);

      // Reset in the middle of a build, then a clean rerun of the single triangle.
      loadVector(0);
      loadObjects(3, 1);
      fillGarbage();
      startBuild(3, 1);
      n = 0;
      while (!(RAM_NBR_WE == 4'hF && RAM_NBR_A == 0 && RAM_NBR_Di == 1) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rst_reach_cnt_wr", 32'(n < 2000), 32'd1);
      repeat (4) @(negedge clk);
      checkOutput("rst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1 checkOutput("rst_mid_outputs", outputsOr(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      loadVector(0);
      applyStimulus("rerun", 3, 1);

      // Randomized face lists against the reference model.
      for (int r = 0; r < 20; r++) begin
         vc = $urandom_range(1, 12);
         fc = $urandom_range(0, 8);
         for (int f = 0; f < fc; f++)
            for (int k = 0; k < 3; k++) begin
               if ($urandom_range(0, 19) == 0) cur_face[f][k] = ($urandom_range(0, 1) == 0) ? 0 : vc + 1;
               else cur_face[f][k] = $urandom_range(1, vc);
            end
         refModel(vc, fc);
         applyStimulus($sformatf("rnd%0d", r), vc, fc);
      end

      checkOutput("obj_never_written", 32'(obj_viol), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
